// File: rtl/ioctl_sram_writer.sv
// Buffers ioctl loader bytes in a small FIFO and replays them as timed async-SRAM write cycles.
// Define IOCTL_SRAM_READBACK_VERIFY_EN to add a readback compare after each write.
module ioctl_sram_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int WE_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic [20:0] sram_addr,
    output logic [7:0]  sram_data_o,
    output logic        sram_data_oe,
    input  logic [7:0]  sram_data_i,
    output logic        sram_we_n,
    output logic        busy,
    output logic        overflow,
    output logic [63:0] header,
    output logic        header_valid,
    output logic        done,
    output logic        verify_error,
    output logic [20:0] verify_addr
);

    localparam int AW = $clog2(FIFO_DEPTH);

`ifdef IOCTL_SRAM_READBACK_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WRITE, S_HOLD, S_RDWAIT, S_CHECK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WRITE, S_HOLD} state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pop;
    logic        we_n_q, oe_q;
    logic [20:0] addr_q;
    logic [7:0]  data_q;

    logic [28:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_empty, fifo_full, push, fifo_we, dl_rise, hdr_hit;
    logic        wr_prev_q, dl_prev_q, overflow_q, hv_q, started_q, done_q;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push    = ioctl_download && ioctl_wr && !wr_prev_q;
    // A pop in the same clock frees the slot, so a full FIFO still accepts.
    assign fifo_we = push && (!fifo_full || pop);
    assign dl_rise = ioctl_download && !dl_prev_q;
    assign hdr_hit = push && (ioctl_addr[24:3] == 22'd0);

    always_ff @(posedge clk) begin
        if (fifo_we) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {ioctl_addr[20:0], ioctl_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_we) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (pop)     rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_SETUP;
                    pop     = 1'b1;
                end
            end
            S_SETUP: begin
                state_d = S_WRITE;
                cnt_d   = 4'd0;
            end
            S_WRITE: begin
                if (cnt_q == 4'(WE_CYCLES - 1)) state_d = S_HOLD;
                else                            cnt_d   = cnt_q + 4'd1;
            end
`ifdef IOCTL_SRAM_READBACK_VERIFY_EN
            S_HOLD: begin
                state_d = S_RDWAIT;
                cnt_d   = 4'd0;
            end
            S_RDWAIT: begin
                if (cnt_q == 4'd1) state_d = S_CHECK;
                else               cnt_d   = cnt_q + 4'd1;
            end
            S_CHECK: begin
                state_d = fifo_empty ? S_IDLE : S_SETUP;
                pop     = !fifo_empty;
            end
`else
            S_HOLD: begin
                state_d = fifo_empty ? S_IDLE : S_SETUP;
                pop     = !fifo_empty;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // SRAM strobes are registered from the next state so they stay glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            addr_q  <= 21'd0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_n_q  <= (state_d != S_WRITE);
            oe_q    <= (state_d == S_SETUP) || (state_d == S_WRITE) || (state_d == S_HOLD);
            if (pop) {addr_q, data_q} <= fifo_mem[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_prev_q  <= 1'b0;
            dl_prev_q  <= 1'b0;
            overflow_q <= 1'b0;
            hv_q       <= 1'b0;
            started_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_prev_q <= ioctl_wr;
            dl_prev_q <= ioctl_download;
            done_q    <= 1'b0;
            if (dl_rise) begin
                overflow_q <= 1'b0;
                hv_q       <= 1'b0;
            end
            if (push && fifo_full && !pop)               overflow_q <= 1'b1;
            if (hdr_hit && (ioctl_addr[2:0] == 3'd7))    hv_q       <= 1'b1;
            if (ioctl_download) begin
                started_q <= 1'b1;
            end else if (started_q && fifo_empty && (state_q == S_IDLE)) begin
                done_q    <= 1'b1;
                started_q <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_hdr
        logic [7:0] byte_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                byte_q <= 8'd0;
            end else if (hdr_hit && (ioctl_addr[2:0] == 3'(gi))) begin
                byte_q <= ioctl_data;
            end
        end
        assign header[63-8*gi -: 8] = byte_q;
    end

`ifdef IOCTL_SRAM_READBACK_VERIFY_EN
    logic        verr_q;
    logic [20:0] vaddr_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            verr_q  <= 1'b0;
            vaddr_q <= 21'd0;
        end else begin
            if (dl_rise) verr_q <= 1'b0;
            if ((state_q == S_CHECK) && (sram_data_i != data_q)) begin
                verr_q <= 1'b1;
                if (!verr_q) vaddr_q <= addr_q;
            end
        end
    end
    assign verify_error = verr_q;
    assign verify_addr  = vaddr_q;
`else
    logic unused_sram_data;
    assign unused_sram_data = ^sram_data_i;
    assign verify_error     = 1'b0;
    assign verify_addr      = 21'd0;
`endif

    assign sram_addr    = addr_q;
    assign sram_data_o  = data_q;
    assign sram_data_oe = oe_q;
    assign sram_we_n    = we_n_q;
    assign busy         = !fifo_empty || (state_q != S_IDLE);
    assign overflow     = overflow_q;
    assign header_valid = hv_q;
    assign done         = done_q;

endmodule

// File: tb/tb_ioctl_sram_writer.sv
// Scoreboard bench for ioctl_sram_writer: a timing-level model predicts accepted bytes,
// their SRAM write start cycle, drops, header contents and done pulses.
module tb_ioctl_sram_writer;

    localparam int DEPTH = 4;
    localparam int WE    = 2;
`ifdef IOCTL_SRAM_READBACK_VERIFY_EN
    localparam int PERIOD = WE + 5;
`else
    localparam int PERIOD = WE + 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic [20:0] sram_addr;
    logic [7:0]  sram_data_o;
    logic        sram_data_oe;
    logic [7:0]  sram_data_i = '0;
    logic        sram_we_n;
    logic        busy, overflow, header_valid, done, verify_error;
    logic [63:0] header;
    logic [20:0] verify_addr;

    ioctl_sram_writer #(.FIFO_DEPTH(DEPTH), .WE_CYCLES(WE)) dut (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .sram_addr(sram_addr),
        .sram_data_o(sram_data_o), .sram_data_oe(sram_data_oe), .sram_data_i(sram_data_i),
        .sram_we_n(sram_we_n), .busy(busy), .overflow(overflow), .header(header),
        .header_valid(header_valid), .done(done), .verify_error(verify_error),
        .verify_addr(verify_addr)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [20:0] addr;
        logic [7:0]  data;
        int          start;
    } exp_t;

    exp_t        expq[$];
    int          pend[$];
    int          last_pop = -1000;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    bit          exp_ovf = 0;
    bit          exp_hv = 0;
    bit          corrupt_en = 0;
    logic [7:0]  hdr_m [8];
    logic [7:0]  mem [int];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: each accepted byte is popped one clock after its push when the writer is idle,
    // otherwise one write period after the previous pop; a full FIFO drops the byte.
    task automatic model_push(input int t, input logic [24:0] a, input logic [7:0] d);
        int p;
        while (pend.size() > 0 && pend[0] <= t) pend.delete(0);
        if (a[24:3] == 22'd0) begin
            hdr_m[a[2:0]] = d;
            if (a[2:0] == 3'd7) exp_hv = 1;
        end
        if (pend.size() >= DEPTH) begin
            exp_ovf = 1;
            $display("push  t=%0d addr=%0h data=%0h dropped", t, a, d);
        end else begin
            p = (t + 1 > last_pop + PERIOD) ? t + 1 : last_pop + PERIOD;
            last_pop = p;
            pend.push_back(p);
            expq.push_back('{a[20:0], d, p + 1});
        end
    endtask

    task automatic model_reset();
        expq.delete();
        pend.delete();
        last_pop = -1000;
        exp_ovf = 0;
        exp_hv = 0;
        for (int k = 0; k < 8; k++) hdr_m[k] = 8'h00;
    endtask

    function automatic logic [63:0] exp_header();
        logic [63:0] h;
        for (int k = 0; k < 8; k++) h[63-8*k -: 8] = hdr_m[k];
        return h;
    endfunction

    task automatic strobe(input logic [24:0] a, input logic [7:0] d, input int gap);
        @(negedge clk);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        model_push(cyc + 1, a, d);
        @(negedge clk);
        ioctl_wr = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic dl_start();
        @(negedge clk);
        ioctl_download = 1'b1;
        exp_ovf = 0;
        exp_hv = 0;
        @(negedge clk);
    endtask

    task automatic dl_stop();
        @(negedge clk);
        ioctl_download = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int  c0;
        bit  seen;
        c0 = done_cnt;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done_cnt != c0) seen = 1;
        end
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
        chk({name, "_queue_drained"}, 64'(expq.size()), 64'd0);
        repeat (4) @(negedge clk);
        chk({name, "_done_once"}, 64'(done_cnt - c0), 64'd1);
        chk({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Monitor: every SRAM write is popped from the scoreboard and checked.
    initial begin
        exp_t cur;
        bit   in_wr;
        int   low_len;
        in_wr = 0;
        low_len = 0;
        cur = '{21'd0, 8'd0, 0};
        forever begin
            @(negedge clk);
            if (reset) begin
                in_wr = 0;
                low_len = 0;
            end else begin
                if (!sram_we_n) begin
                    if (!in_wr) begin
                        in_wr = 1;
                        low_len = 1;
                        if (expq.size() == 0) begin
                            chk("unexpected_write", {43'd0, sram_addr}, 64'h1FFFFFFFF);
                        end else begin
                            cur = expq.pop_front();
                            $display("write cyc=%0d addr=%06h data=%02h", cyc, sram_addr, sram_data_o);
                            chk("write_start_cycle", 64'(cyc), 64'(cur.start));
                            mem[int'(cur.addr)] = cur.data;
                        end
                    end else begin
                        low_len++;
                    end
                    chk("write_addr", {43'd0, sram_addr}, {43'd0, cur.addr});
                    chk("write_data", {56'd0, sram_data_o}, {56'd0, cur.data});
                    chk("write_oe", 64'(sram_data_oe), 64'd1);
                end else if (in_wr) begin
                    in_wr = 0;
                    chk("we_low_len", 64'(low_len), 64'(WE));
                end
                if (done) done_cnt++;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SRAM read model; address 0x10 can be made to read back inverted.
    initial forever begin
        logic [7:0] v;
        @(negedge clk);
        v = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : 8'h00;
        if (corrupt_en && sram_addr == 21'h10) v = ~v;
        sram_data_i = v;
    end

    initial begin
        int dc;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_we_n", 64'(sram_we_n), 64'd1);
        chk("rst_oe", 64'(sram_data_oe), 64'd0);
        chk("rst_addr", {43'd0, sram_addr}, 64'd0);
        chk("rst_data", {56'd0, sram_data_o}, 64'd0);
        chk("rst_header", header, 64'd0);
        chk("rst_status", {58'd0, busy, overflow, header_valid, done, verify_error, 1'b0}, 64'd0);
        chk("rst_vaddr", {43'd0, verify_addr}, 64'd0);
        reset = 1'b0;

        // Single byte
        dl_start();
        strobe(25'h000005, 8'hA5, 0);
        dl_stop();
        wait_done("single");

        // Header capture
        dl_start();
        for (int k = 0; k < 8; k++) strobe(25'(k), 8'(8'h11 * (k + 1)), 1);
        dl_stop();
        wait_done("header");
        chk("header_value", header, 64'h1122334455667788);
        chk("header_valid", 64'(header_valid), 64'd1);

        // Burst beyond FIFO capacity
        dl_start();
        for (int k = 0; k < 12; k++) strobe(25'h100 + 25'(k), 8'(8'hC0 + k), 0);
        chk("burst_overflow_model", 64'(exp_ovf), 64'd1);
        dl_stop();
        wait_done("burst");
        chk("burst_overflow", 64'(overflow), 64'(exp_ovf));
        dl_start();
        chk("overflow_cleared", 64'(overflow), 64'd0);
        chk("hv_cleared", 64'(header_valid), 64'd0);
        dl_stop();
        wait_done("empty_dl");

        // Drain: download falls with three entries queued
        dl_start();
        for (int k = 0; k < 3; k++) strobe(25'h200 + 25'(k), 8'(8'h30 + k), 0);
        dl_stop();
        wait_done("drain");
        chk("drain_overflow", 64'(overflow), 64'd0);

        // Randomized downloads
        for (int r = 0; r < 4; r++) begin
            dl_start();
            for (int k = 0; k < 20; k++) begin
                logic [24:0] a;
                if ($urandom_range(0, 1) == 1) a = 25'($urandom_range(0, 15));
                else                           a = 25'($urandom());
                strobe(a, 8'($urandom()), int'($urandom_range(0, 5)));
            end
            dl_stop();
            wait_done("random");
            chk("random_overflow", 64'(overflow), 64'(exp_ovf));
            chk("random_header", header, exp_header());
            chk("random_hv", 64'(header_valid), 64'(exp_hv));
        end

`ifdef IOCTL_SRAM_READBACK_VERIFY_EN
        dl_start();
        corrupt_en = 1;
        strobe(25'h10, 8'h3C, 0);
        strobe(25'h11, 8'h77, 0);
        dl_stop();
        wait_done("verify_bad");
        chk("verify_error_set", 64'(verify_error), 64'd1);
        chk("verify_addr", {43'd0, verify_addr}, 64'h10);
        corrupt_en = 0;
        dl_start();
        chk("verify_error_cleared", 64'(verify_error), 64'd0);
        strobe(25'h10, 8'h5D, 0);
        strobe(25'h20, 8'h6E, 0);
        dl_stop();
        wait_done("verify_clean");
        chk("verify_clean", 64'(verify_error), 64'd0);
`else
        chk("verify_error_tied", 64'(verify_error), 64'd0);
        chk("verify_addr_tied", {43'd0, verify_addr}, 64'd0);
`endif

        // Reset during WRITE with a second entry still queued
        dl_start();
        strobe(25'h1234, 8'h5A, 0);
        strobe(25'h1235, 8'h5B, 0);
        for (int i = 0; i < 20 && sram_we_n; i++) @(negedge clk);
        chk("rst_reached_write", 64'(sram_we_n), 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_we_n", 64'(sram_we_n), 64'd1);
        chk("rst_async_oe", 64'(sram_data_oe), 64'd0);
        chk("rst_async_busy", 64'(busy), 64'd0);
        chk("rst_async_addr", {43'd0, sram_addr}, 64'd0);
        chk("rst_async_header", header, 64'd0);
        model_reset();
        ioctl_download = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        dc = done_cnt;
        repeat (30) @(negedge clk);
        chk("rst_no_done", 64'(done_cnt - dc), 64'd0);
        chk("rst_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
